// File: rtl/alu_pkg.sv
// Shared types for the pipelined add/sub unit.
// Operand-stage P/G bundle and result flags.
package alu_pkg;

   localparam int ADD_W = 16;

   typedef struct packed {
      logic [ADD_W-1:0] p;
      logic [ADD_W-1:0] g;
      logic             cin;
   } pg_word_t;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
      logic neg;
   } alu_flags_t;

endpackage

// File: rtl/carry_tree_bk_16b.sv
// 16-bit Brent-Kung parallel-prefix carry tree.
// carry_o[i] is the carry out of bit i given per-bit P/G.
module carry_tree_bk_16b (
   input  logic [15:0] prop_i,
   input  logic [15:0] gen_i,
   output logic [15:0] carry_o
);

   logic [15:0] gg;
   logic [15:0] pp;

   always_comb begin
      gg = gen_i;
      pp = prop_i;
      // up-sweep builds power-of-two spans, down-sweep fills the gaps
      for (int d = 0; d < 4; d++) begin
         for (int i = (2 << d) - 1; i < 16; i += (2 << d)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
            pp[i] = pp[i] & pp[i - (1 << d)];
         end
      end
      for (int d = 2; d >= 0; d--) begin
         for (int i = (3 << d) - 1; i < 16; i += (2 << d)) begin
            gg[i] = gg[i] | (pp[i] & gg[i - (1 << d)]);
            pp[i] = pp[i] & pp[i - (1 << d)];
         end
      end
   end

   assign carry_o = gg;

endmodule

// File: rtl/pg_gen_16b.sv
// Operand conditioning for add/sub and per-bit P/G generation.
// Subtract is A + ~B + 1, so cin is forced high.
module pg_gen_16b
   import alu_pkg::*;
(
   input  logic [ADD_W-1:0] a_i,
   input  logic [ADD_W-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   output pg_word_t         pg_o
);

   logic [ADD_W-1:0] bb;

   assign bb        = sub_i ? ~b_i : b_i;
   assign pg_o.p    = a_i ^ bb;
   assign pg_o.g    = a_i & bb;
   assign pg_o.cin  = sub_i | cin_i;

endmodule

// File: rtl/bk_adder_pipe_16b.sv
// Two-stage pipelined 16-bit add/sub with valid/ready on both sides.
// Stage 1 registers P/G, stage 2 resolves carries and registers results.
module bk_adder_pipe_16b
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [ADD_W-1:0] a_i,
   input  logic [ADD_W-1:0] b_i,
   input  logic             cin_i,
   input  logic             sub_i,
   input  logic [TAG_W-1:0] tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [ADD_W-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o,
   output logic             zero_o,
   output logic             neg_o,
   output logic [TAG_W-1:0] tag_o
);

   logic             s1_valid;
   pg_word_t         s1_pg;
   logic [TAG_W-1:0] s1_tag;
   pg_word_t         pg_d;
   logic             s2_load;
   logic             in_fire;
   logic [ADD_W-1:0] g_in;
   logic [ADD_W-1:0] carry;
   logic [ADD_W-1:0] s2_sum;
   alu_flags_t       s2_flags;

   assign s2_load    = s1_valid && (!out_valid_o || out_ready_i);
   assign in_ready_o = !s1_valid || s2_load;
   assign in_fire    = in_valid_i && in_ready_o;

   pg_gen_16b u_pg_gen (
      .a_i   (a_i),
      .b_i   (b_i),
      .cin_i (cin_i),
      .sub_i (sub_i),
      .pg_o  (pg_d)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         s1_pg    <= '0;
         s1_tag   <= '0;
      end else if (in_fire) begin
         s1_valid <= 1'b1;
         s1_pg    <= pg_d;
         s1_tag   <= tag_i;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   // fold carry-in into bit 0 generate so the tree needs no cin port
   always_comb begin
      g_in    = s1_pg.g;
      g_in[0] = s1_pg.g[0] | (s1_pg.p[0] & s1_pg.cin);
   end

   carry_tree_bk_16b u_carry_tree (
      .prop_i  (s1_pg.p),
      .gen_i   (g_in),
      .carry_o (carry)
   );

   assign s2_sum        = s1_pg.p ^ {carry[ADD_W-2:0], s1_pg.cin};
   assign s2_flags.cout = carry[ADD_W-1];
   assign s2_flags.ovf  = carry[ADD_W-1] ^ carry[ADD_W-2];
   assign s2_flags.zero = (s2_sum == '0);
   assign s2_flags.neg  = s2_sum[ADD_W-1];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_valid_o <= 1'b0;
         sum_o       <= '0;
         cout_o      <= 1'b0;
         ovf_o       <= 1'b0;
         zero_o      <= 1'b0;
         neg_o       <= 1'b0;
         tag_o       <= '0;
      end else if (s2_load) begin
         out_valid_o <= 1'b1;
         sum_o       <= s2_sum;
         cout_o      <= s2_flags.cout;
         ovf_o       <= s2_flags.ovf;
         zero_o      <= s2_flags.zero;
         neg_o       <= s2_flags.neg;
         tag_o       <= s1_tag;
      end else if (out_ready_i) begin
         out_valid_o <= 1'b0;
      end
   end

endmodule
